// File: rtl/conv_strip_feeder.sv
// Buffers one image row and emits overlapping 2x5 pixel strips for conv_core_1channel_2x2.
// Each strip steps by four columns and shares one column with the previous strip.
module conv_strip_feeder #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 9,
   parameter int IMG_H  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [10*DATA_W-1:0]  image,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic [DATA_W-1:0]   line [IMG_W];
   logic [5*DATA_W-1:0] prv_tap;
   logic [5*DATA_W-1:0] cur_tap;
   logic [5*DATA_W-1:0] prv_next;
   logic [5*DATA_W-1:0] cur_next;
   logic                pix_xfer;
   logic                emit;
   logic                col_end;
   logic                row_end;

   // Handshake: a beat moves on a rising edge when valid and ready are both high.
   // The producer holds a beat until it moves. A pixel is refused while a pending
   // strip is still unconsumed, so no strip is ever overwritten.
   assign in_ready = rst_n & (~out_valid | out_ready);
   assign pix_xfer = in_valid & in_ready;
   assign col_end  = (col == COL_W'(IMG_W - 1));
   assign row_end  = (row == ROW_W'(IMG_H - 1));

   // Newest pixel enters at the low end, so the oldest column lands in the top byte.
   assign prv_next = {prv_tap[4*DATA_W-1:0], line[col]};
   assign cur_next = {cur_tap[4*DATA_W-1:0], in_data};

   assign emit = pix_xfer & (row != '0) & (col >= COL_W'(4)) & (col[1:0] == 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         prv_tap   <= '0;
         cur_tap   <= '0;
         image     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         for (int i = 0; i < IMG_W; i++) begin
            line[i] <= '0;
         end
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (pix_xfer) begin
            prv_tap   <= prv_next;
            cur_tap   <= cur_next;
            line[col] <= in_data;
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            // An emit on the same edge as a strip transfer overrides the clear above.
            if (emit) begin
               image     <= {prv_next, cur_next};
               out_valid <= 1'b1;
               out_last  <= row_end & col_end;
            end
         end
      end
   end

endmodule

// File: doc/conv_strip_feeder.md
# conv_strip_feeder

Upstream feeder for `conv_core_1channel_2x2`. It accepts a raster-order 8-bit pixel stream with valid/ready handshake and buffers one image row. It emits 2-row × 5-column pixel strips on the `image` bus format the core consumes. Successive strips overlap by one column, so the core's four 16-bit outputs tile each output row with no gaps.

## Interface
Parameters:
- `DATA_W`, 8: pixel width; the strip bus is fixed by the core at 8 bits per pixel, so only 8 is supported.
- `IMG_W`, 9: image width in pixels; requires `IMG_W >= 5` and `(IMG_W-1) % 4 == 0`.
- `IMG_H`, 3: image height in rows; requires `IMG_H >= 2`.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_data`, input, 8: pixel, raster order, row 0 column 0 first.
- `in_valid`, input, 1: `in_data` valid.
- `in_ready`, output, 1: feeder can accept a pixel.
- `image`, output, 80: strip, packed `{r0c0,r0c1,r0c2,r0c3,r0c4,r1c0,…,r1c4}`; r0 is the upper (older) row; r0c0 sits in [79:72] and r1c4 in [7:0].
- `out_valid`, output, 1: `image` holds a strip.
- `out_ready`, input, 1: downstream accepts the strip.
- `out_last`, output, 1: qualifies `out_valid`; marks the final strip of a frame.

## Operation
- Pixel transfer occurs on a rising edge with `in_valid & in_ready`. Strip transfer occurs on `out_valid & out_ready`.
- `col` counter, 0..IMG_W-1, and `row` counter, 0..IMG_H-1, advance on each pixel transfer.
  - `col` wraps to 0 after IMG_W-1, and `row` then increments.
  - After pixel (IMG_H-1, IMG_W-1), both counters wrap to 0 and the next pixel starts a new frame. There is no explicit start-of-frame signal.
- Line buffer: IMG_W × 8 registers holding the previous row. Two 5-deep tap shift registers are kept: `prv_tap` and `cur_tap`.
- On each pixel transfer at column c:
  - Shift `line[c]` into `prv_tap`.
  - Shift `in_data` into `cur_tap`.
  - Write `line[c] <= in_data`.
  - Taps reset to 0 when `col` wraps, or are simply overwritten; their contents at c < 4 are don't-care.
- Strip emit condition: the transferred pixel has `row >= 1`, `col >= 4` and `col % 4 == 0`.
  - On that edge, load `image` from the post-shift taps. Columns are c-4..c of rows row-1 and row.
  - Set `out_valid` to 1.
  - Set `out_last = (row == IMG_H-1) & (col == IMG_W-1)`.
- Strips per frame: (IMG_H-1) × (IMG_W-1)/4. Row 0 produces no strips.
- `in_ready = rst_n & (~out_valid | out_ready)`. A pixel is never accepted while an unconsumed strip could be overwritten.
- On a strip transfer with no new emit on the same edge, `out_valid` and `out_last` go to 0. `image` holds its last value.
- Simultaneous strip transfer and new emit on the same edge: the new strip loads and `out_valid` stays 1. No bubble and no loss.
- While `out_valid & ~out_ready`: `image` and `out_last` are held stable and no pixels are accepted.
- Reset, including mid-frame: counters → 0, `out_valid` → 0, `out_last` → 0, `image` → 0. Line buffer and taps → 0. A partial frame is discarded, and the next accepted pixel is (0,0).

## Timing
- Latency: the strip is visible in the cycle after the edge that accepted its last pixel (column c of row ≥ 1). This is a 1-cycle registered output.
- Throughput: 1 pixel/cycle when `out_ready` is held high, including back-to-back emits (e.g. IMG_W=5 with IMG_H large).
- `in_ready` is combinational from `out_valid`, `out_ready` and `rst_n`. There are no other combinational input→output paths.
- Outputs during and immediately after reset: `in_ready` = 0 while `rst_n` = 0. In the first cycle after release, `in_ready` = 1 and `out_valid` = 0.

## Test plan
- **Basic frame, default parameters, free-flowing:**
  - Stimulus: pixels `r*16+c`, `out_ready=1`.
  - First strip, after pixel (1,4): `{0,1,2,3,4,16,17,18,19,20}`.
  - Second strip: `{4,5,6,7,8,20,21,22,23,24}`.
  - Exactly 4 strips in total.
  - Last strip: `{20..24, 36..40}` with `out_last=1`; `out_last=0` on the other three.
- **Backpressure:**
  - Stimulus: hold `out_ready=0` for 6 cycles after the first strip.
  - `image` stays at `{0,1,2,3,4,16,17,18,19,20}` and `in_ready=0` throughout.
  - After release, the remaining strips are unchanged and no pixel is dropped or duplicated.
- **Input gaps:** randomly deassert `in_valid` (≈50%) → the strip sequence and values are identical to the first scenario.
- **Two consecutive frames:**
  - Frame 2 uses pixel values `100+r*16+c`.
  - Frame 2's first strip is `{100..104, 116..120}`; no strip from frame 1 carries over.
- **Reset mid-frame:**
  - Assert `rst_n=0` for 1 cycle after pixel (1,6).
  - `out_valid=0`, `image=0` and `in_ready=0` during reset.
  - Then a full fresh frame reproduces the first scenario's output exactly.
- **Handoff to the core:**
  - Set the core's `filter={1,2,1,0}` and drive the core's `image` from the feeder's `image` output.
  - For the first strip, the core's outputs match a golden-model 2×2 convolution of `{0..4 ; 16..20}`.
